// File: rtl/cpu_top.sv
// Multi-cycle RV64I-subset core: FETCH -> EXEC (-> MEM for loads) -> FETCH, with a terminal HALT.
// 64-bit register file and PC; instruction and data memories are external with one-cycle read latency.
module cpu_top #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst_rdata,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   output logic [3:0]  data_we,
   input  logic [31:0] data_rdata,
   output logic [63:0] debug_pc,
   output logic [31:0] debug_inst,
   output logic        debug_halt
);
   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

   state_t      state;
   logic [63:0] pc;
   logic [63:0] regs [0:31];
   logic [4:0]  load_rd;

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [5:0]  sh_imm;
   logic [5:0]  sh_reg;

   logic [63:0] rs1_val;
   logic [63:0] rs2_val;
   logic [63:0] imm_i;
   logic [31:0] imm_s;
   logic [63:0] imm_b;
   logic [63:0] imm_u;
   logic [63:0] imm_j;

   logic        legal;
   logic        wr_en;
   logic [63:0] wr_val;
   logic [63:0] next_pc;
   logic        is_load;
   logic        is_store;
   logic        taken;

   assign opcode = inst_rdata[6:0];
   assign rd     = inst_rdata[11:7];
   assign funct3 = inst_rdata[14:12];
   assign rs1    = inst_rdata[19:15];
   assign rs2    = inst_rdata[24:20];
   assign funct7 = inst_rdata[31:25];
   assign sh_imm = inst_rdata[25:20];

   assign rs1_val = (rs1 == 5'd0) ? 64'd0 : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 64'd0 : regs[rs2];
   assign sh_reg  = rs2_val[5:0];

   assign imm_i = {{52{inst_rdata[31]}}, inst_rdata[31:20]};
   assign imm_s = {{20{inst_rdata[31]}}, inst_rdata[31:25], inst_rdata[11:7]};
   assign imm_b = {{51{inst_rdata[31]}}, inst_rdata[31], inst_rdata[7], inst_rdata[30:25],
                   inst_rdata[11:8], 1'b0};
   assign imm_u = {{32{inst_rdata[31]}}, inst_rdata[31:12], 12'd0};
   assign imm_j = {{43{inst_rdata[31]}}, inst_rdata[31], inst_rdata[19:12], inst_rdata[20],
                   inst_rdata[30:21], 1'b0};

   // Decode/execute is purely combinational on the word returned during EXEC.
   always_comb begin
      legal    = 1'b0;
      wr_en    = 1'b0;
      wr_val   = 64'd0;
      next_pc  = pc + 64'd4;
      is_load  = 1'b0;
      is_store = 1'b0;
      taken    = 1'b0;
      case (opcode)
         7'b0110111: begin
            legal  = 1'b1;
            wr_en  = 1'b1;
            wr_val = imm_u;
         end
         7'b0010111: begin
            legal  = 1'b1;
            wr_en  = 1'b1;
            wr_val = pc + imm_u;
         end
         7'b1101111: begin
            legal   = 1'b1;
            wr_en   = 1'b1;
            wr_val  = pc + 64'd4;
            next_pc = pc + imm_j;
         end
         7'b1100111: begin
            legal   = (funct3 == 3'b000);
            wr_en   = 1'b1;
            wr_val  = pc + 64'd4;
            next_pc = (rs1_val + imm_i) & ~64'd1;
         end
         7'b1100011: begin
            legal = 1'b1;
            case (funct3)
               3'b000:  taken = (rs1_val == rs2_val);
               3'b001:  taken = (rs1_val != rs2_val);
               3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
               3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
               3'b110:  taken = (rs1_val <  rs2_val);
               3'b111:  taken = (rs1_val >= rs2_val);
               default: legal = 1'b0;
            endcase
            if (taken) next_pc = pc + imm_b;
         end
         7'b0000011: begin
            legal   = (funct3 == 3'b010);
            is_load = legal;
         end
         7'b0100011: begin
            legal    = (funct3 == 3'b010);
            is_store = legal;
         end
         7'b0010011: begin
            legal = 1'b1;
            wr_en = 1'b1;
            case (funct3)
               3'b000: wr_val = rs1_val + imm_i;
               3'b010: wr_val = {63'd0, $signed(rs1_val) < $signed(imm_i)};
               3'b011: wr_val = {63'd0, rs1_val < imm_i};
               3'b100: wr_val = rs1_val ^ imm_i;
               3'b110: wr_val = rs1_val | imm_i;
               3'b111: wr_val = rs1_val & imm_i;
               3'b001: begin
                  legal  = (funct7[6:1] == 6'b000000);
                  wr_val = rs1_val << sh_imm;
               end
               3'b101: begin
                  legal  = (funct7[6:1] == 6'b000000) || (funct7[6:1] == 6'b010000);
                  wr_val = funct7[5] ? $unsigned($signed(rs1_val) >>> sh_imm) : (rs1_val >> sh_imm);
               end
            endcase
         end
         7'b0110011: begin
            wr_en = 1'b1;
            legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            case (funct3)
               3'b000: wr_val = funct7[5] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
               3'b001: wr_val = rs1_val << sh_reg;
               3'b010: wr_val = {63'd0, $signed(rs1_val) < $signed(rs2_val)};
               3'b011: wr_val = {63'd0, rs1_val < rs2_val};
               3'b100: wr_val = rs1_val ^ rs2_val;
               3'b101: wr_val = funct7[5] ? $unsigned($signed(rs1_val) >>> sh_reg) : (rs1_val >> sh_reg);
               3'b110: wr_val = rs1_val | rs2_val;
               3'b111: wr_val = rs1_val & rs2_val;
            endcase
         end
         default: legal = 1'b0;
      endcase
   end

   assign inst_addr  = pc[31:0];
   assign data_addr  = rs1_val[31:0] + ((opcode == 7'b0100011) ? imm_s : imm_i[31:0]);
   assign data_wdata = rs2_val[31:0];
   assign data_we    = ((state == EXEC) && is_store) ? 4'b1111 : 4'b0000;
   assign debug_pc   = pc;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         debug_inst <= 32'd0;
         debug_halt <= 1'b0;
         for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
      end else begin
         case (state)
            FETCH: state <= EXEC;
            EXEC: begin
               debug_inst <= inst_rdata;
               if (!legal) begin
                  state      <= HALT;
                  debug_halt <= 1'b1;
               end else if (is_load) begin
                  load_rd <= rd;
                  state   <= MEM;
               end else begin
                  if (wr_en && (rd != 5'd0)) regs[rd] <= wr_val;
                  pc    <= next_pc;
                  state <= FETCH;
               end
            end
            MEM: begin
               if (load_rd != 5'd0) regs[load_rd] <= {{32{data_rdata[31]}}, data_rdata};
               pc    <= pc + 64'd4;
               state <= FETCH;
            end
            HALT: state <= HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: directed program scenarios plus random programs compared with an ISS model.
module tb_cpu_top;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load_dmem = 1'b0;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_we;
   logic [31:0] data_rdata;
   logic [63:0] debug_pc;
   logic [31:0] debug_inst;
   logic        debug_halt;

   logic [31:0] imem  [0:255];
   logic [31:0] dmem  [0:255];
   logic [31:0] dinit [0:255];
   logic [31:0] dref  [0:255];
   logic [63:0] xref  [0:31];
   int n_pass = 0;
   int n_chk  = 0;

   cpu_top #(.RESET_PC(64'h0)) dut (
      .clk(clk), .reset(reset),
      .inst_addr(inst_addr), .inst_rdata(inst_rdata),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_we(data_we),
      .data_rdata(data_rdata),
      .debug_pc(debug_pc), .debug_inst(debug_inst), .debug_halt(debug_halt)
   );

   always #5 clk = ~clk;

   // Synchronous memories, one-cycle read latency.
   always @(posedge clk) begin
      inst_rdata <= imem[inst_addr[9:2]];
      data_rdata <= dmem[data_addr[9:2]];
      if (load_dmem) begin
         for (int i = 0; i < 256; i++) dmem[i] <= dinit[i];
      end else if (data_we == 4'b1111) begin
         dmem[data_addr[9:2]] <= data_wdata;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start();
      reset     = 1'b0;
      load_dmem = 1'b1;
      tick(2);
      load_dmem = 1'b0;
      reset     = 1'b1;
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rd, op};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction

   // Instruction-level reference: one instruction per iteration, returns total cycles to halt.
   task automatic iss_run(output int cyc, output logic [63:0] hpc, output logic [31:0] hword);
      logic [63:0] pc, a, b, res, npc, ii, iu, ib, ij, ea;
      logic [31:0] w, ld;
      logic [2:0]  f3;
      logic        ok, wr;
      int          cpi;
      pc = 64'd0; cyc = 0; hpc = 64'd0; hword = 32'd0;
      for (int r = 0; r < 32; r++) xref[r] = 64'd0;
      for (int s = 0; s < 1000; s++) begin
         w  = imem[pc[9:2]];
         f3 = w[14:12];
         a  = xref[w[19:15]];
         b  = xref[w[24:20]];
         ii = {{52{w[31]}}, w[31:20]};
         iu = {{32{w[31]}}, w[31:12], 12'd0};
         ib = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         ij = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         ok = 1'b1; wr = 1'b1; res = 64'd0; npc = pc + 64'd4; cpi = 2;
         case (w[6:0])
            7'h37: res = iu;
            7'h17: res = pc + iu;
            7'h6f: begin res = pc + 64'd4; npc = pc + ij; end
            7'h67: begin
               ok = (f3 == 3'd0); res = pc + 64'd4; npc = (a + ii) & ~64'd1;
            end
            7'h63: begin
               wr = 1'b0;
               case (f3)
                  3'd0: if (a == b) npc = pc + ib;
                  3'd1: if (a != b) npc = pc + ib;
                  3'd4: if ($signed(a) < $signed(b)) npc = pc + ib;
                  3'd5: if ($signed(a) >= $signed(b)) npc = pc + ib;
                  3'd6: if (a < b) npc = pc + ib;
                  3'd7: if (a >= b) npc = pc + ib;
                  default: ok = 1'b0;
               endcase
            end
            7'h03: begin
               ok = (f3 == 3'd2); ea = a + ii; ld = dref[ea[9:2]];
               res = {{32{ld[31]}}, ld}; cpi = 3;
            end
            7'h23: begin
               ok = (f3 == 3'd2); wr = 1'b0;
               ea = a + {{52{w[31]}}, w[31:25], w[11:7]};
               if (ok) dref[ea[9:2]] = b[31:0];
            end
            7'h13: case (f3)
               3'd0: res = a + ii;
               3'd2: res = ($signed(a) < $signed(ii)) ? 64'd1 : 64'd0;
               3'd3: res = (a < ii) ? 64'd1 : 64'd0;
               3'd4: res = a ^ ii;
               3'd6: res = a | ii;
               3'd7: res = a & ii;
               3'd1: begin ok = (w[31:26] == 6'd0); res = a << w[25:20]; end
               default: begin
                  ok  = (w[31:26] == 6'd0) || (w[31:26] == 6'b010000);
                  res = w[30] ? $unsigned($signed(a) >>> w[25:20]) : a >> w[25:20];
               end
            endcase
            7'h33: begin
               ok = (w[31:25] == 7'd0) || (w[31:25] == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
               case (f3)
                  3'd0: res = w[30] ? a - b : a + b;
                  3'd1: res = a << b[5:0];
                  3'd2: res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                  3'd3: res = (a < b) ? 64'd1 : 64'd0;
                  3'd4: res = a ^ b;
                  3'd5: res = w[30] ? $unsigned($signed(a) >>> b[5:0]) : a >> b[5:0];
                  3'd6: res = a | b;
                  default: res = a & b;
               endcase
            end
            default: ok = 1'b0;
         endcase
         if (!ok) begin
            cyc += 2; hpc = pc; hword = w;
            return;
         end
         if (wr && w[11:7] != 5'd0) xref[w[11:7]] = res;
         pc = npc;
         cyc += cpi;
      end
      cyc = -1;
   endtask

   // Random straight-line program with forward-only control flow, ending in a halting word.
   task automatic gen_prog(input int n);
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [11:0] i12;
      int          k, kmax, sel;
      for (int i = 0; i < 256; i++) imem[i] = 32'd0;
      for (int i = 0; i < n; i++) begin
         rd   = 5'($urandom_range(0, 7));
         rs1  = 5'($urandom_range(0, 7));
         rs2  = 5'($urandom_range(0, 7));
         f3   = 3'($urandom_range(0, 7));
         i12  = 12'($urandom);
         kmax = (n - i < 4) ? n - i : 4;
         k    = int'($urandom_range(1, kmax));
         case ($urandom_range(0, 9))
            0, 1: begin
               if (f3 == 3'd1) i12 = {6'd0, i12[5:0]};
               else if (f3 == 3'd5) i12 = {1'b0, i12[10], 4'd0, i12[5:0]};
               imem[i] = enc_i(i12, rs1, f3, rd, 7'h13);
            end
            2, 3: imem[i] = enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                                  rs2, rs1, f3, rd);
            4: imem[i] = enc_u(20'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17);
            5: imem[i] = enc_s(12'(4 * $urandom_range(0, 255)), rs2, 5'd0);
            6: imem[i] = enc_i(12'(4 * $urandom_range(0, 255)), 5'd0, 3'd2, rd, 7'h03);
            7: begin
               sel = int'($urandom_range(0, 5));
               f3  = (sel < 2) ? 3'(sel) : 3'(sel + 2);
               imem[i] = enc_b(13'(4 * k), rs2, rs1, f3);
            end
            8: imem[i] = enc_j(21'(4 * k), rd);
            default: imem[i] = enc_i(12'(4 * (i + k) + int'($urandom_range(0, 1))), 5'd0, 3'd0, rd, 7'h67);
         endcase
      end
      case ($urandom_range(0, 3))
         0: imem[n] = 32'h00000000;
         1: imem[n] = 32'h00000073;
         2: imem[n] = 32'h00100073;
         default: imem[n] = 32'hFFFFFFFF;
      endcase
   endtask

   initial begin
      int          exp_cyc, cyc, errs;
      logic [63:0] exp_pc;
      logic [31:0] exp_word;
      for (int i = 0; i < 256; i++) begin imem[i] = 32'd0; dinit[i] = 32'd0; end

      // Reset and first fetch
      imem[0] = 32'h00300293; imem[1] = 32'h00310313; imem[2] = 32'h006282b3;
      imem[3] = 32'h00300193; imem[4] = 32'h00028463; imem[5] = 32'h00300393;
      imem[6] = 32'h0000006F;
      start();
      check("rst_pc", debug_pc, 64'h0);
      check("rst_we", 64'(data_we), 64'h0);
      check("rst_halt", 64'(debug_halt), 64'h0);
      check("rst_iaddr", 64'(inst_addr), 64'h0);

      // ALU sequence, not-taken branch, self-loop
      tick(2); check("t2_x5", dut.regs[5], 64'd3); check("t2_pc4", debug_pc, 64'h4);
      check("t2_inst", 64'(debug_inst), 64'h00300293);
      tick(2); check("t2_x6", dut.regs[6], 64'd3); check("t2_pc8", debug_pc, 64'h8);
      tick(2); check("t2_x5b", dut.regs[5], 64'd6); check("t2_pcC", debug_pc, 64'hC);
      tick(2); check("t2_x3", dut.regs[3], 64'd3); check("t2_pc10", debug_pc, 64'h10);
      tick(2); check("t3_beq_nt", debug_pc, 64'h14);
      tick(2); check("t3_x7", dut.regs[7], 64'd3); check("t3_pc18", debug_pc, 64'h18);
      tick(10); check("t3_loop_pc", debug_pc, 64'h18); check("t3_nohalt", 64'(debug_halt), 64'h0);
      check("t3_x0", dut.regs[0], 64'd0);

      // Halt on an all-zero word, then reset out of it
      imem[6] = 32'h00000013; imem[7] = 32'h00000000;
      start();
      tick(14); check("t5_pc1C", debug_pc, 64'h1C);
      tick(2); check("t5_halt", 64'(debug_halt), 64'h1); check("t5_pc", debug_pc, 64'h1C);
      check("t5_inst", 64'(debug_inst), 64'h0);
      tick(6); check("t5_frozen", debug_pc, 64'h1C); check("t5_we", 64'(data_we), 64'h0);
      reset = 1'b0; tick(1);
      check("t5_rst_halt", 64'(debug_halt), 64'h0); check("t5_rst_pc", debug_pc, 64'h0);
      reset = 1'b1;

      // Store then load of all-ones
      for (int i = 0; i < 256; i++) imem[i] = 32'd0;
      imem[0] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd5, 7'h13);
      imem[1] = enc_s(12'd16, 5'd5, 5'd0);
      imem[2] = enc_i(12'd16, 5'd0, 3'd2, 5'd6, 7'h03);
      start();
      tick(2); check("t4_x5", dut.regs[5], 64'hFFFF_FFFF_FFFF_FFFF);
      tick(1); check("t4_sw_addr", 64'(data_addr), 64'h10);
      check("t4_sw_data", 64'(data_wdata), 64'hFFFFFFFF); check("t4_sw_we", 64'(data_we), 64'hF);
      tick(1); check("t4_we_off", 64'(data_we), 64'h0); check("t4_pc8", debug_pc, 64'h8);
      tick(1); check("t4_lw_addr", 64'(data_addr), 64'h10); check("t4_lw_we", 64'(data_we), 64'h0);
      tick(1); check("t4_mem_x6", dut.regs[6], 64'd0);
      tick(1); check("t4_x6", dut.regs[6], 64'hFFFF_FFFF_FFFF_FFFF); check("t4_pcC", debug_pc, 64'hC);
      check("t4_dmem", 64'(dmem[4]), 64'hFFFFFFFF);
      tick(2); check("t4_halt", 64'(debug_halt), 64'h1);

      // Reset during MEM of a load
      for (int i = 0; i < 256; i++) imem[i] = 32'd0;
      imem[0] = enc_i(12'd16, 5'd0, 3'd2, 5'd6, 7'h03);
      dinit[4] = 32'h12345678;
      start();
      tick(2);
      reset = 1'b0; tick(1);
      check("t6_x6", dut.regs[6], 64'd0); check("t6_pc", debug_pc, 64'h0);
      reset = 1'b1;
      tick(3); check("t6_reload", dut.regs[6], 64'h12345678); check("t6_pc4", debug_pc, 64'h4);

      // Random programs against the ISS
      for (int p = 0; p < 8; p++) begin
         gen_prog(40);
         for (int i = 0; i < 256; i++) begin dinit[i] = $urandom; dref[i] = dinit[i]; end
         iss_run(exp_cyc, exp_pc, exp_word);
         start();
         cyc = 0;
         while (!debug_halt && cyc < 2000) begin tick(1); cyc++; end
         check("rnd_cycles", 64'(cyc), 64'(exp_cyc));
         check("rnd_pc", debug_pc, exp_pc);
         check("rnd_inst", 64'(debug_inst), 64'(exp_word));
         for (int r = 1; r < 32; r++) check($sformatf("rnd_x%0d", r), dut.regs[r], xref[r]);
         errs = 0;
         for (int i = 0; i < 256; i++) if (dmem[i] !== dref[i]) errs++;
         check("rnd_dmem", 64'(errs), 64'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/cpu_top.md
Name: cpu_top

Overview:
Multi-cycle, in-order RV64I-subset processor core with 64-bit registers and PC, driving 32-bit instruction and data memory ports.
- Both memories are synchronous with one-cycle read latency: address presented in cycle N, data valid in cycle N+1.
- Debug outputs expose the current PC, the last executed instruction and a halt flag.
- Top-level core of the design; memories are external.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset.
inst_addr  output  32  instruction fetch address, equal to pc[31:0].
inst_rdata  input  32  instruction word, valid one cycle after inst_addr is presented.
data_addr  output  32  load/store effective address, bits [31:0] of rs1+imm.
data_wdata  output  32  store data, rs2[31:0].
data_we  output  4  byte write enables: 4'b1111 for SW, 4'b0000 otherwise.
data_rdata  input  32  load data, valid one cycle after data_addr is presented.
debug_pc  output  64  current PC register.
debug_inst  output  32  instruction latched in the last EXEC cycle.
debug_halt  output  1  high once the core has halted.

Behaviour:
Reset (reset==0 at a rising edge):
- pc=RESET_PC; state=FETCH; x1..x31=0.
- debug_inst=0; debug_halt=0; data_we=0.
- Reset mid-instruction aborts that instruction without any register write.

FSM states: FETCH, EXEC, MEM, HALT.
- FETCH: inst_addr=pc[31:0]; data_we=0; next state EXEC.
- EXEC: decode inst_rdata; latch it into debug_inst; compute the result.
  - Non-load instructions: write rd at the end of EXEC, update pc, return to FETCH.
  - Load: drive data_addr, go to MEM.
  - Store: drive data_addr, data_wdata and data_we=4'b1111 during EXEC only; memory writes at the end-of-EXEC edge.
- MEM: rd = sign-extended data_rdata; pc += 4; go to FETCH.
- HALT: terminal until reset; pc frozen; data_we=0; debug_halt=1.

Timing:
- CPI is 2 for all instructions except loads, which take 3.
- inst_addr holds pc[31:0] in every state.

Supported instructions (RV64I encodings):
- LUI, AUIPC.
- JAL; JALR (target bit 0 cleared).
- BEQ, BNE, BLT, BGE, BLTU, BGEU.
- LW (sign-extend to 64 bits); SW.
- ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI (6-bit shamt).
- ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA (shift amount rs2[5:0]).

Arithmetic and register rules:
- All arithmetic is 64-bit, wrapping; immediates are sign-extended to 64 bits.
- x0 always reads 0; writes to x0 are discarded.
- JAL/JALR write pc+4 to rd.

Next PC:
- Taken branch: pc+imm (B-imm).
- JAL: pc+J-imm.
- Otherwise: pc+4.

Halt conditions:
- Any unsupported opcode, including 32'h00000000, or ECALL/EBREAK, in EXEC causes HALT with no architectural update.
- debug_inst holds the offending word; debug_pc holds its address.

Other rules:
- Misaligned addresses are not trapped; low address bits are passed through unchanged.

Test Plan:
1. Hold reset=0 for 2 cycles, then release -> debug_pc=0, data_we=0, debug_halt=0, first fetch from inst_addr=0.
2. Program 0x00300293, 0x00310313, 0x006282b3, 0x00300193 at 0x0..0xC -> x5=3, then x6=3 (x2=0), then x5=6, x3=3; debug_pc advances by 4 every 2 cycles.
3. 0x00028463 (beq x5,x0,+8) at 0x10 with x5=6 -> not taken, pc=0x14; 0x00300393 -> x7=3; 0x0000006F at 0x18 -> pc stays 0x18 forever, x0 unchanged, no halt.
4. addi x5,x0,-1; sw x5,16(x0) -> one cycle with data_addr=0x10, data_wdata=0xFFFFFFFF, data_we=4'b1111; lw x6,16(x0) with memory returning 0xFFFFFFFF -> x6=0xFFFFFFFFFFFFFFFF after 3 cycles.
5. Fetch of 0x00000000 at 0x1C -> debug_halt=1, debug_pc=0x1C, debug_inst=0; pc frozen; reset clears the halt.
6. Assert reset during the MEM state of a load -> rd is not written; pc=0; FSM restarts in FETCH.
